// File: rtl/parity_pkg.sv
// Shared constants, mode encodings and the nibble XOR helper for the parity pipeline.
package parity_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Parity sense selected by odd_mode.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    // Operating mode selected by chk_mode.
    typedef enum logic {
        MODE_GEN = 1'b0,
        MODE_CHK = 1'b1
    } chk_mode_e;

    // Two-level tree of 2-input XORs over one nibble.
    function automatic logic nibble_xor(input logic [NIBBLE_W-1:0] nib);
        return (nib[0] ^ nib[1]) ^ (nib[2] ^ nib[3]);
    endfunction

endpackage

// File: rtl/xor_nibble_tree.sv
// Combinational reduction of a DATA_W-bit word to one XOR partial per nibble.
module xor_nibble_tree
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W/NIBBLE_W-1:0] nib_par_o
);

    localparam int unsigned NumNib = DATA_W / NIBBLE_W;

    for (genvar i = 0; i < NumNib; i++) begin : g_nib
        assign nib_par_o[i] = nibble_xor(data_i[i*NIBBLE_W +: NIBBLE_W]);
    end

endmodule

// File: rtl/parity_pipe_acc.sv
// Two-stage streaming parity generator/checker with per-packet parity accumulation
// and a saturating mismatch counter.
module parity_pipe_acc
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    input  logic              chk_mode,
    input  logic              clr_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_word_par,
    output logic              out_pkt_par,
    output logic              out_last,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned NumNib = DATA_W / NIBBLE_W;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [NumNib-1:0] s1_nib_q, s1_nib_d;
    logic              s1_last_q, s1_last_d;
    par_mode_e         s1_odd_q, s1_odd_d;
    chk_mode_e         s1_chk_q, s1_chk_d;
    logic              s1_par_q, s1_par_d;

    // Stage 2 (output) state
    logic              out_valid_q, out_valid_d;
    logic              out_word_par_q, out_word_par_d;
    logic              out_pkt_par_q, out_pkt_par_d;
    logic              out_last_q, out_last_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              acc_q, acc_d;

    logic [NumNib-1:0] nib_par;
    logic              adv;
    logic              accept;
    logic              load;
    logic              word_par;
    logic              pkt_par;
    logic              mismatch;

    xor_nibble_tree #(
        .DATA_W (DATA_W)
    ) u_tree (
        .data_i    (in_data),
        .nib_par_o (nib_par)
    );

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv || !s1_valid_q;
    assign accept   = in_valid && in_ready;
    // A real word moves into the output stage; bubbles only clear out_valid.
    assign load     = adv && s1_valid_q;

    assign word_par = (^s1_nib_q) ^ (s1_odd_q == PAR_ODD);
    assign pkt_par  = acc_q ^ word_par;
    assign mismatch = (s1_chk_q == MODE_CHK) && (word_par != s1_par_q);

    // Stage 1 next state: refill on accept, drain when stage 2 takes the word.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_nib_d   = s1_nib_q;
        s1_last_d  = s1_last_q;
        s1_odd_d   = s1_odd_q;
        s1_chk_d   = s1_chk_q;
        s1_par_d   = s1_par_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_nib_d   = nib_par;
            s1_last_d  = in_last;
            s1_odd_d   = par_mode_e'(odd_mode);
            s1_chk_d   = chk_mode_e'(chk_mode);
            s1_par_d   = in_par;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: final XOR, packet accumulation, checker and counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_word_par_d = out_word_par_q;
        out_pkt_par_d  = out_pkt_par_q;
        out_last_d     = out_last_q;
        out_err_d      = out_err_q;
        acc_d          = acc_q;
        err_count_d    = err_count_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
        end
        if (load) begin
            out_word_par_d = word_par;
            out_last_d     = s1_last_q;
            out_err_d      = mismatch;
            if (s1_last_q) begin
                out_pkt_par_d = pkt_par;
                acc_d         = 1'b0;
            end else begin
                acc_d = pkt_par;
            end
            if (mismatch && err_count_q != CntMax) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
        // Clear wins over a coincident mismatch.
        if (clr_cnt) begin
            err_count_d = '0;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_nib_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_odd_q   <= PAR_EVEN;
            s1_chk_q   <= MODE_GEN;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_nib_q   <= s1_nib_d;
            s1_last_q  <= s1_last_d;
            s1_odd_q   <= s1_odd_d;
            s1_chk_q   <= s1_chk_d;
            s1_par_q   <= s1_par_d;
        end
    end

    // Stage 2 / accumulator / counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_word_par_q <= 1'b0;
            out_pkt_par_q  <= 1'b0;
            out_last_q     <= 1'b0;
            out_err_q      <= 1'b0;
            err_count_q    <= '0;
            acc_q          <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_word_par_q <= out_word_par_d;
            out_pkt_par_q  <= out_pkt_par_d;
            out_last_q     <= out_last_d;
            out_err_q      <= out_err_d;
            err_count_q    <= err_count_d;
            acc_q          <= acc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_word_par = out_word_par_q;
    assign out_pkt_par  = out_pkt_par_q;
    assign out_last     = out_last_q;
    assign out_err      = out_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_parity_pipe_acc.sv
// Scoreboard bench: the driver pushes hand-computed expectations on each accepted word,
// a negedge monitor pops and compares on each output transfer.
module tb_parity_pipe_acc;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_par = 1'b0;
    logic              odd_mode = 1'b0;
    logic              chk_mode = 1'b0;
    logic              clr_cnt = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_word_par;
    logic              out_pkt_par;
    logic              out_last;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic wp;
        int   pp;     // -1: not checked
        logic last;
        logic err;
        int   cnt;
        int   acc_cyc;
        bit   lat;
    } exp_t;

    exp_t sb_q[$];

    parity_pipe_acc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_par       (in_par),
        .odd_mode     (odd_mode),
        .chk_mode     (chk_mode),
        .clr_cnt      (clr_cnt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word_par (out_word_par),
        .out_pkt_par  (out_pkt_par),
        .out_last     (out_last),
        .out_err      (out_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: output transfers against the scoreboard, plus hold-stable during stalls.
    bit   stalled = 1'b0;
    logic [5:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_hold", {26'b0, out_word_par, out_pkt_par, out_last, out_err,
                                     err_count}, {26'b0, held});
            end
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                held = {out_word_par, out_pkt_par, out_last, out_err, err_count};
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got a result, expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("word_par[%h]", e.data), {31'b0, out_word_par}, {31'b0, e.wp});
                    check($sformatf("last[%h]", e.data), {31'b0, out_last}, {31'b0, e.last});
                    check($sformatf("err[%h]", e.data), {31'b0, out_err}, {31'b0, e.err});
                    check($sformatf("err_count[%h]", e.data), {30'b0, err_count}, e.cnt);
                    if (e.pp >= 0)
                        check($sformatf("pkt_par[%h]", e.data), {31'b0, out_pkt_par}, e.pp);
                    if (e.lat)
                        check($sformatf("latency[%h]", e.data), cyc - e.acc_cyc, 32'd2);
                end
            end
        end
    end

    // Present one word and hold it until accepted; inputs change #1 after the edge.
    task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic odd,
                        input logic chk, input logic ipar, input logic ewp, input int epp,
                        input logic eerr, input int ecnt, input bit lat);
        bit done = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = odd;
        chk_mode = chk;
        in_par   = ipar;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = '{data: d, wp: ewp, pp: epp, last: last, err: eerr, cnt: ecnt,
                      acc_cyc: cyc, lat: lat};
                done = 1'b1;
            end
            @(posedge clk);
        end
        if (done) sb_q.push_back(e);
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%h]: in_ready never high, expected accept", d);
        end
        #1;
    endtask

    task automatic idle_drain();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_err_count", {30'b0, err_count}, 32'd0);
        check("rst_outs", {28'b0, out_word_par, out_pkt_par, out_last, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Generate, even; in_par deliberately set to check out_err stays 0
        send(16'h0000, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        send(16'h8001, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        send(16'h0007, 1, 0, 0, 0, 1, 1, 0, 0, 1);
        send(16'hFFFF, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        // Generate, odd
        send(16'h0000, 1, 1, 0, 0, 1, 1, 0, 0, 1);
        send(16'h8001, 1, 1, 0, 0, 1, 1, 0, 0, 1);
        send(16'h0007, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        send(16'hFFFF, 1, 1, 0, 0, 1, 1, 0, 0, 1);
        // Multi-word packet then single-word packet
        send(16'h0001, 0, 0, 0, 0, 1, -1, 0, 0, 1);
        send(16'h0003, 0, 0, 0, 0, 0, -1, 0, 0, 1);
        send(16'h0007, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        send(16'h0010, 1, 0, 0, 0, 1, 1, 0, 0, 1);
        idle_drain();

        // Backpressure: stall output ~5 cycles while streaming
        fork
            begin
                send(16'h0001, 1, 0, 0, 0, 1, 1, 0, 0, 0);
                send(16'h0003, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                send(16'h00FF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                send(16'h0101, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                send(16'h7000, 1, 0, 0, 0, 1, 1, 0, 0, 0);
                send(16'h1F00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle_drain();

        // Check mode, wrong in_par: counter saturates at 3
        send(16'h0001, 1, 0, 1, 0, 1, 1, 1, 1, 0);
        send(16'h0003, 1, 0, 1, 1, 0, 0, 1, 2, 0);
        send(16'h0007, 1, 0, 1, 0, 1, 1, 1, 3, 0);
        send(16'h000F, 1, 0, 1, 1, 0, 0, 1, 3, 0);
        send(16'h001F, 1, 0, 1, 0, 1, 1, 1, 3, 0);
        // Correct in_par
        send(16'h0003, 1, 0, 1, 0, 0, 0, 0, 3, 0);
        idle_drain();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1 clr_cnt = 1'b0;
        check("clr_cnt", {30'b0, err_count}, 32'd0);
        // Clear coinciding with a mismatch: clear wins
        clr_cnt = 1'b1;
        send(16'h0001, 1, 0, 1, 0, 1, 1, 1, 0, 0);
        idle_drain();
        clr_cnt = 1'b0;
        // Odd-mode check mismatch
        send(16'h0000, 1, 1, 1, 0, 1, 1, 1, 1, 0);
        idle_drain();

        // Reset mid-packet
        send(16'h0001, 0, 0, 0, 0, 1, -1, 0, 1, 0);
        idle_drain();
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_err_count", {30'b0, err_count}, 32'd0);
        check("mid_rst_outs", {28'b0, out_word_par, out_pkt_par, out_last, out_err}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0003, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_pipe_acc.md
Name: parity_pipe_acc

Overview:
- Parametrised successor to the fixed 4-bit XOR-tree parity block: a DATA_W-bit parity generator/checker built as a registered 2-stage XOR reduction tree.
- Streaming valid/ready input and output, even/odd parity selection, and per-packet parity accumulation.
- Check mode compares against a supplied parity bit and keeps a saturating error counter.
- Sits between a word-stream producer and a link/packet framer.

Parameters:
- DATA_W, 16, input word width; must be a multiple of 4 and >= 4.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  data word.
- in_last  in  1  word is the last of a packet.
- in_par  in  1  expected parity bit; used in check mode only.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled with each accepted word.
- chk_mode  in  1  0 = generate, 1 = check; sampled with each accepted word.
- clr_cnt  in  1  synchronous clear of err_count.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_word_par  out  1  parity bit of the word.
- out_pkt_par  out  1  packet parity; meaningful only when out_last = 1.
- out_last  out  1  echo of in_last.
- out_err  out  1  check-mode mismatch for this word; always 0 in generate mode.
- err_count  out  CNT_W  saturating mismatch count.

Behaviour:
- Parity definitions:
  - Even mode: word parity = XOR of all in_data bits.
  - Odd mode: word parity = inverse of that XOR.
- Handshake:
  - An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
  - adv = !out_valid | out_ready.
  - in_ready = adv | !s1_valid (stage 1 can refill when it is empty).
  - Stage 1 (s1): on accept, registers DATA_W/4 nibble partial XORs, plus last, odd_mode, chk_mode, in_par and s1_valid.
  - Stage 2 (output): on adv, loads from s1. out_valid <= s1_valid. The final XOR of the partials and the odd inversion are applied here.
  - Latency: 2 cycles from input transfer to out_valid when there is no stall. Throughput is 1 word/cycle.
  - While out_valid & !out_ready, all outputs hold stable and s1 holds its word; in_ready is low only when s1 is full and the output is stalled.
- Packet accumulator:
  - acc holds the XOR of the word parities emitted since the last packet end.
  - On each output load: pkt = acc ^ word_par.
  - If last: out_pkt_par <= pkt and acc <= 0. Otherwise acc <= pkt.
  - acc therefore updates on stage-2 load, not on output transfer.
  - Mixing odd_mode within a packet is legal: each word's own parity is used.
- Checker:
  - In check mode, out_err = (word_par != in_par).
  - On a stage-2 load with out_err = 1, err_count increments and saturates at 2^CNT_W - 1.
  - clr_cnt has priority: when clr_cnt and an error coincide, err_count becomes 0.
- Reset: asynchronous, active-low.
  - All of the following go to 0: out_valid, s1_valid, out_word_par, out_pkt_par, out_last, out_err, err_count, acc.
  - in_ready = 1 after reset.
  - Reset mid-packet discards the in-flight words and the partial packet parity; the next word starts a new packet.
- Boundaries:
  - A single-word packet (in_last on the first word) gives out_pkt_par = out_word_par.
  - A bubble (no input) leaves acc unchanged.

Decomposition:
- Package parity_pkg holds:
  - NIBBLE_W = 4;
  - the enum constants PAR_EVEN/PAR_ODD and MODE_GEN/MODE_CHK;
  - a function for the XOR reduction of a nibble.
- Sub-module xor_nibble_tree: combinational DATA_W → DATA_W/4 nibble reduction built from 2-input XORs, instantiated in stage 1.
- Accumulator, checker and handshake logic stay in the top module.

Test Plan:
- Generate mode, even, DATA_W=16, no stall: inputs 0x0000, 0x8001, 0x0007, 0xFFFF → out_word_par 0, 0, 1, 0, each 2 cycles after acceptance, one result per cycle.
- Odd mode with the same words → out_word_par 1, 1, 0, 1.
- Packet 0x0001, 0x0003, 0x0007(last), then 0x0010(last) → word parities 1, 0, 1; out_pkt_par 0 on the third result; then 1 for the single-word packet.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 streaming → out_* stable, in_ready drops after s1 fills, no word lost or duplicated, results resume in order.
- Check mode, CNT_W=2: send 5 words with in_par wrong → out_err=1 each, err_count goes 1, 2, 3, 3; then clr_cnt → 0. Correct in_par → out_err=0.
- Reset asserted mid-packet after 0x0001 → outputs and err_count 0 immediately; after release, packet 0x0003(last) → out_pkt_par 0.
